// File: rtl/iscas_bist_ctrl.sv
// rtl/iscas_bist_ctrl.sv - LFSR/MISR BIST session controller for 7-in/7-out ISCAS CUTs
// One start request yields an all-zero preamble, then PATTERNS LFSR vectors with MISR compaction.
module iscas_bist_ctrl #(
  parameter int unsigned PATTERNS    = 127,
  parameter int unsigned INIT_CYCLES = 4,
  parameter logic [6:0]  SEED        = 7'h01
) (
  input  logic       i_clk,
  input  logic       i_rst,
  input  logic       i_start,
  input  logic [6:0] i_golden,
  input  logic [6:0] i_cut_out,
  output logic [6:0] o_cut_in,
  output logic       o_busy,
  output logic       o_done,
  output logic       o_pass,
  output logic [6:0] o_signature,
  output logic [7:0] o_pattern_cnt
);

  // An all-zero seed would lock the LFSR, so it is replaced with 1.
  localparam logic [6:0]  LFSR_SEED = (SEED == 7'h00) ? 7'h01 : SEED;
  localparam logic [15:0] INIT_LAST = (INIT_CYCLES > 0) ? 16'(INIT_CYCLES - 1) : 16'd0;
  localparam logic [7:0]  PAT_LAST  = 8'(PATTERNS - 1);

  typedef enum logic [1:0] {S_IDLE, S_INIT, S_RUN, S_DONE} state_t;

  state_t      r_state;
  logic [6:0]  r_lfsr;
  logic [6:0]  r_misr;
  logic [7:0]  r_cnt;
  logic [15:0] r_init_cnt;
  logic        r_busy;
  logic        r_done;

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state    <= S_IDLE;
      r_lfsr     <= LFSR_SEED;
      r_misr     <= 7'h00;
      r_cnt      <= 8'd0;
      r_init_cnt <= 16'd0;
      r_busy     <= 1'b0;
      r_done     <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE, S_DONE: begin
          if (i_start) begin
            r_state    <= (INIT_CYCLES == 0) ? S_RUN : S_INIT;
            r_lfsr     <= LFSR_SEED;
            r_misr     <= 7'h00;
            r_cnt      <= 8'd0;
            r_init_cnt <= 16'd0;
            r_busy     <= 1'b1;
            r_done     <= 1'b0;
          end
        end
        S_INIT: begin
          if (r_init_cnt == INIT_LAST) begin
            r_state <= S_RUN;
          end else begin
            r_init_cnt <= r_init_cnt + 16'd1;
          end
        end
        S_RUN: begin
          // cut_out here is the CUT response to the pattern still on cut_in.
          r_lfsr <= {r_lfsr[5:0], r_lfsr[6] ^ r_lfsr[5]};
          r_misr <= {r_misr[5:0], r_misr[6] ^ r_misr[5]} ^ i_cut_out;
          r_cnt  <= r_cnt + 8'd1;
          if (r_cnt == PAT_LAST) begin
            r_state <= S_DONE;
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_cut_in      = (r_state == S_RUN) ? r_lfsr : 7'h00;
  assign o_busy        = r_busy;
  assign o_done        = r_done;
  assign o_pass        = r_done && (r_misr == i_golden);
  assign o_signature   = r_misr;
  assign o_pattern_cnt = r_cnt;

endmodule

// File: tb/tb_iscas_bist_ctrl.sv
// tb/tb_iscas_bist_ctrl.sv - directed bench for iscas_bist_ctrl
// Instance a: default session with a behavioural CUT; instance b: 2-pattern session driven from a table.
module tb_iscas_bist_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic       a_start, b_start;
  logic [6:0] a_golden, b_golden;
  logic [6:0] a_cut_out, b_cut_out;
  logic [6:0] a_cut_in, b_cut_in;
  logic       a_busy, a_done, a_pass, b_busy, b_done, b_pass;
  logic [6:0] a_sig, b_sig;
  logic [7:0] a_cnt, b_cnt;
  logic       fault;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  function automatic logic [6:0] cut_fn(input logic [6:0] x);
    return {x[3:0], x[6:4]} ^ 7'h2A ^ {6'd0, x[6] & x[0]};
  endfunction

  // Stuck-at-0 on v13_D_9 (bit 3) when fault is set.
  assign a_cut_out = fault ? (cut_fn(a_cut_in) & 7'h77) : cut_fn(a_cut_in);

  iscas_bist_ctrl u_a (
    .i_clk(clk), .i_rst(rst), .i_start(a_start), .i_golden(a_golden),
    .i_cut_out(a_cut_out), .o_cut_in(a_cut_in), .o_busy(a_busy), .o_done(a_done),
    .o_pass(a_pass), .o_signature(a_sig), .o_pattern_cnt(a_cnt)
  );

  iscas_bist_ctrl #(.PATTERNS(2), .INIT_CYCLES(0), .SEED(7'h00)) u_b (
    .i_clk(clk), .i_rst(rst), .i_start(b_start), .i_golden(b_golden),
    .i_cut_out(b_cut_out), .o_cut_in(b_cut_in), .o_busy(b_busy), .o_done(b_done),
    .o_pass(b_pass), .o_signature(b_sig), .o_pattern_cnt(b_cnt)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s actual=%0h required=%0h", name, act, exp);
    end
  endtask

  function automatic logic [6:0] model_sig(input logic flt);
    logic [6:0] l;
    logic [6:0] m;
    logic [6:0] co;
    l = 7'h01;
    m = 7'h00;
    for (int i = 0; i < 127; i++) begin
      co = cut_fn(l);
      if (flt) co[3] = 1'b0;
      m = {m[5:0], m[6] ^ m[5]} ^ co;
      l = {l[5:0], l[6] ^ l[5]};
    end
    return m;
  endfunction

  // Leaves the bench at the falling edge inside the first cycle after E0.
  task automatic start_a();
    @(negedge clk);
    a_start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    a_start = 1'b0;
  endtask

  task automatic wait_done_a(input string name);
    int k;
    for (k = 0; k < 400; k++) begin
      if (a_done) break;
      @(negedge clk);
    end
    chk(name, a_done, 1'b1);
  endtask

  typedef struct {
    logic [6:0] co;
    logic [6:0] gold;
    logic [6:0] sig;
    logic       pass;
  } vec_t;

  vec_t       tbl[5];
  logic [6:0] seq_exp[8];
  logic [6:0] good_sig, bad_sig, m, co;
  bit         seen[128];
  int         dup;

  initial begin
    rst = 1'b1; a_start = 1'b0; b_start = 1'b0; fault = 1'b0;
    a_golden = 7'h00; b_golden = 7'h00; b_cut_out = 7'h00;
    tbl[0] = '{co: 7'h01, gold: 7'h03, sig: 7'h03, pass: 1'b1};
    tbl[1] = '{co: 7'h00, gold: 7'h00, sig: 7'h00, pass: 1'b1};
    tbl[2] = '{co: 7'h01, gold: 7'h02, sig: 7'h03, pass: 1'b0};
    tbl[3] = '{co: 7'h7F, gold: 7'h01, sig: 7'h01, pass: 1'b1};
    tbl[4] = '{co: 7'h40, gold: 7'h41, sig: 7'h41, pass: 1'b1};
    seq_exp = '{7'h01, 7'h02, 7'h04, 7'h08, 7'h10, 7'h20, 7'h41, 7'h03};
    good_sig = model_sig(1'b0);
    bad_sig  = model_sig(1'b1);

    #12;
    chk("rst_cut_in", a_cut_in, 7'h00);
    chk("rst_busy", a_busy, 1'b0);
    chk("rst_done", a_done, 1'b0);
    chk("rst_pass", a_pass, 1'b0);
    chk("rst_sig", a_sig, 7'h00);
    chk("rst_cnt", a_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;

    // Two-pattern signature arithmetic, seed 0 replaced by 1.
    for (int t = 0; t < 5; t++) begin
      b_cut_out = tbl[t].co;
      b_golden  = tbl[t].gold;
      @(negedge clk);
      b_start = 1'b1;
      @(posedge clk);
      @(negedge clk);
      b_start = 1'b0;
      chk($sformatf("b%0d_cyc1_in", t), b_cut_in, 7'h01);
      chk($sformatf("b%0d_busy", t), b_busy, 1'b1);
      @(negedge clk);
      chk($sformatf("b%0d_cyc2_in", t), b_cut_in, 7'h02);
      chk($sformatf("b%0d_not_done", t), b_done, 1'b0);
      @(negedge clk);
      chk($sformatf("b%0d_done", t), b_done, 1'b1);
      chk($sformatf("b%0d_sig", t), b_sig, tbl[t].sig);
      chk($sformatf("b%0d_pass", t), b_pass, tbl[t].pass);
      chk($sformatf("b%0d_cnt", t), b_cnt, 8'd2);
      chk($sformatf("b%0d_cut_in_done", t), b_cut_in, 7'h00);
    end

    // Framing, sequence and ignored start pulses on the default instance.
    m = 7'h00; dup = 0;
    for (int i = 0; i < 128; i++) seen[i] = 1'b0;
    start_a();
    for (int c = 1; c <= 131; c++) begin
      chk($sformatf("a_busy_c%0d", c), a_busy, 1'b1);
      if (c <= 4) begin
        chk($sformatf("a_init_in_c%0d", c), a_cut_in, 7'h00);
      end else begin
        if (c - 5 < 8) chk($sformatf("a_seq%0d", c - 5), a_cut_in, seq_exp[c - 5]);
        if (seen[a_cut_in] || a_cut_in == 7'h00) dup++;
        seen[a_cut_in] = 1'b1;
        co = cut_fn(a_cut_in);
        m = {m[5:0], m[6] ^ m[5]} ^ co;
      end
      if (c == 131) chk("a_done_early", a_done, 1'b0);
      a_start = (c == 2 || c == 60);
      @(negedge clk);
    end
    a_start = 1'b0;
    chk("a_seq_unique", dup, 0);
    chk("a_done_131", a_done, 1'b1);
    chk("a_busy_fall", a_busy, 1'b0);
    chk("a_cnt_127", a_cnt, 8'd127);
    chk("a_sig_model", a_sig, m);
    chk("a_sig_ref", a_sig, good_sig);
    a_golden = good_sig;
    #1 chk("a_pass_good", a_pass, 1'b1);
    a_golden = good_sig ^ 7'h01;
    #1 chk("a_pass_flip", a_pass, 1'b0);
    a_golden = good_sig;
    repeat (3) @(negedge clk);
    chk("a_sig_frozen", a_sig, good_sig);
    chk("a_cnt_frozen", a_cnt, 8'd127);

    // Restart with start held high in DONE.
    a_start = 1'b1;
    @(posedge clk);
    #1;
    chk("rs_sig_clear", a_sig, 7'h00);
    chk("rs_busy", a_busy, 1'b1);
    chk("rs_done", a_done, 1'b0);
    repeat (3) @(negedge clk);
    a_start = 1'b0;
    wait_done_a("rs_timeout");
    chk("rs_sig", a_sig, good_sig);
    chk("rs_pass", a_pass, 1'b1);
    @(negedge clk);
    chk("rs_once", a_busy, 1'b0);

    // Stuck-at-0 on v13_D_9.
    fault = 1'b1;
    start_a();
    wait_done_a("sa0_timeout");
    chk("sa0_sig", a_sig, bad_sig);
    chk("sa0_pass", a_pass, 1'(bad_sig == good_sig));
    fault = 1'b0;

    // Reset during RUN cycle 10.
    start_a();
    repeat (13) @(negedge clk);
    chk("mid_in_run", a_cut_in == 7'h00, 1'b0);
    rst = 1'b1;
    #1;
    chk("mid_cut_in", a_cut_in, 7'h00);
    chk("mid_busy", a_busy, 1'b0);
    chk("mid_done", a_done, 1'b0);
    chk("mid_pass", a_pass, 1'b0);
    chk("mid_sig", a_sig, 7'h00);
    chk("mid_cnt", a_cnt, 8'd0);
    @(negedge clk);
    rst = 1'b0;
    start_a();
    wait_done_a("post_timeout");
    chk("post_sig", a_sig, good_sig);
    chk("post_cnt", a_cnt, 8'd127);
    chk("post_pass", a_pass, 1'b1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/iscas_bist_ctrl.md
# iscas_bist_ctrl

Built-in self-test harness for the small ISCAS sequential benchmarks with 7 primary inputs and 7 primary outputs (s386 class). It drives the circuit-under-test (CUT) inputs from a 7-bit maximal-length LFSR and compacts the CUT outputs into a 7-bit MISR signature. On request it runs a fixed-length test session and reports pass/fail against a supplied golden signature. It sits beside the CUT on the same clock and replaces the external tester for at-speed sessions.

## Interface
- PATTERNS, 127, number of RUN cycles per session; legal range 1..255.
- INIT_CYCLES, 4, cycles of all-zero preamble applied before RUN to settle CUT state; 0 is legal.
- SEED, 7'h01, LFSR load value at session start; SEED==0 is replaced by 7'h01.
- CK  in  1  clock, rising edge; shared with the CUT flip-flops.
- RST  in  1  reset, asynchronous, active-high.
- start  in  1  session request; sampled only in IDLE or DONE.
- golden  in  7  expected signature; must be stable while done=1.
- cut_out  in  7  CUT primary outputs {v13_D_12..v13_D_6}, bit 6 = v13_D_12.
- cut_in  out  7  CUT primary inputs {v6..v0}, bit 0 = v0.
- busy  out  1  high in INIT and RUN.
- done  out  1  high in DONE.
- pass  out  1  done && (signature == golden), combinational from registered state.
- signature  out  7  current MISR contents.
- pattern_cnt  out  8  RUN cycles completed in the current session.

## Operation
- States: IDLE, INIT, RUN, DONE. Registered outputs only, except pass and cut_in (decoded from state/LFSR).
- IDLE: cut_in=0. start=1 -> INIT (or RUN if INIT_CYCLES==0). Load lfsr=SEED, misr=0, pattern_cnt=0, init counter=0.
- INIT: cut_in=7'h00. MISR holds. After INIT_CYCLES cycles -> RUN.
- RUN: cut_in=lfsr. On each edge: lfsr <= {lfsr[5:0], lfsr[6]^lfsr[5]}; misr <= {misr[5:0], misr[6]^misr[5]} ^ cut_out; pattern_cnt++. The edge that completes cycle PATTERNS -> DONE.
- DONE: cut_in=0. signature, pattern_cnt frozen. start=1 -> restart exactly as from IDLE (misr cleared, lfsr reloaded).
- start in INIT/RUN is ignored. start held high in DONE restarts once per DONE visit; a new session starts immediately.
- LFSR polynomial x^7+x^6+1, period 127; the all-zero state is unreachable.
- RST asserted at any time, including mid-RUN: state=IDLE, lfsr=SEED (or 1), misr=0, pattern_cnt=0, busy=done=pass=0, cut_in=0 immediately (asynchronous). Aborted sessions leave no residue.

## Timing
- Reset values: cut_in=0, busy=0, done=0, pass=0, signature=0, pattern_cnt=0.
- start sampled at edge E0; busy=1 from E0 through the edge ending the last RUN cycle.
- INIT occupies cycles 1..INIT_CYCLES after E0; RUN occupies the next PATTERNS cycles.
- cut_out is captured at the edge ending each RUN cycle, while cut_in still holds that cycle's pattern; CUT combinational response within one CK period is required.
- done=1 at edge E0+INIT_CYCLES+PATTERNS; busy falls at the same edge.
- pattern_cnt equals PATTERNS in DONE; it never wraps (PATTERNS <= 255).

## Test plan
- Reset mid-RUN: assert RST in RUN cycle 10 -> all outputs 0 in same cycle, state IDLE; next start yields a full, unaffected session.
- Sequence check: SEED=1, INIT_CYCLES=0, start -> cut_in over the first 8 RUN cycles = 01,02,04,08,10,20,41,03; over 127 cycles every nonzero value appears exactly once.
- Signature arithmetic: PATTERNS=2, cut_out tied 7'h01 -> signature=7'h03; cut_out tied 0 for any PATTERNS -> signature=7'h00.
- Framing: INIT_CYCLES=4, PATTERNS=127 -> cut_in=0 for 4 cycles, done exactly 131 edges after start, pattern_cnt=127, start pulses during busy ignored.
- Pass/fail with real s386 netlist: golden from a gate-level reference run -> pass=1; flip golden bit 0 -> pass=0; inject stuck-at-0 on v13_D_9 -> pass=0.
- Restart from DONE: start held high in DONE -> signature cleared to 0 one edge later, a second identical session reproduces the same signature.
